// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared constants for the neural-network datapath blocks.
//   FL           fractional bits of the Q8.24 format
//   ONE_POS      +1.0 in Q8.24
//   ONE_NEG      -1.0 in Q8.24
//   SIGMOID_LAT  default latency of the sigmoid activation unit (enabled cycles)
//   clog2()      ceiling log2 usable in parameter expressions
// Include-guarded so a file may pull it in textually as well as by compile order.
// -----------------------------------------------------------------------------
`ifndef NN_PKG_SV
`define NN_PKG_SV

package nn_pkg;

    localparam int          FL          = 24;
    localparam logic [31:0] ONE_POS     = 32'h0100_0000;
    localparam logic [31:0] ONE_NEG     = 32'hFF00_0000;
    localparam int          SIGMOID_LAT = 2;

    // Smallest r with (1 << r) >= n; bounded loop so it stays a constant function.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans req starting at ptr and wrapping
// modulo NREQ; the first asserted request wins. With en low nothing is granted.
// Shared with the layer-buffer write scheduler, so it carries no state: the
// caller owns the pointer and decides when it advances.
//
// Ports
//   req    in   NREQ  request vector
//   ptr    in   IDW   index that has highest priority this cycle
//   en     in   1     arbitration enable
//   grant  out  NREQ  one-hot grant (all zero when nothing wins)
//   idx    out  IDW   encoded index of the winner (0 when nothing wins)
// -----------------------------------------------------------------------------
module rr_arbiter
    import nn_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;

    // NOTE: every output of a combinational block gets a default at the top;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[(int'(ptr) + k) % NREQ]) begin
                    grant[(int'(ptr) + k) % NREQ] = 1'b1;
                    idx   = IDW'((int'(ptr) + k) % NREQ);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sigmoid_sched.sv
// -----------------------------------------------------------------------------
// sigmoid_sched
// Shares one external pipelined sigmoid unit (Q8.24, LAT enabled cycles) among
// NREQ neuron requesters. Requests are granted round-robin; each result leaves
// tagged with the ID of the requester that issued it. A result that the
// consumer does not take freezes the whole activation pipeline via act_en.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   req_valid    in   NREQ        per-requester request valid
//   req_data     in   NREQ*WIDTH  pre-activations, requester i at [i*WIDTH +: WIDTH]
//   req_ready    out  NREQ        one-hot accept
//   rsp_valid    out  1           result valid
//   rsp_id       out  IDW         requester owning the result
//   rsp_data     out  WIDTH       result (act_y passed through)
//   rsp_ready    in   1           consumer accepts the result
//   act_en       out  1           pipeline enable of the activation unit
//   act_a        out  WIDTH       operand to the activation unit
//   act_y        in   WIDTH       activation unit output
//   busy         out  1           any result in flight
//
// Optional build macro SIGMOID_SCHED_PERF_EN adds two saturating 16-bit
// counters, perf_grants (accepted requests) and perf_stalls (cycles with
// act_en low), both cleared by rst.
// LAT must be at least 2.
// -----------------------------------------------------------------------------
module sigmoid_sched
    import nn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int LAT   = SIGMOID_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready,
    output logic                  act_en,
    output logic [WIDTH-1:0]      act_a,
    input  logic [WIDTH-1:0]      act_y,
    output logic                  busy
`ifdef SIGMOID_SCHED_PERF_EN
    ,
    output logic [15:0]           perf_grants,
    output logic [15:0]           perf_stalls
`endif
);

    // Shadow of the activation pipeline: one valid bit and one requester ID per
    // stage, advanced exactly when the activation unit itself advances.
    logic [LAT-1:0]          vld_q, vld_d;
    logic [LAT-1:0][IDW-1:0] id_q, id_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            stall;
    logic            transfer;

    // A finished result nobody takes blocks the last stage, so nothing moves.
    assign stall = vld_q[LAT-1] && !rsp_ready;

    // Enable stays high in reset so the activation unit, sharing rst, flushes.
    assign act_en = rst || !stall;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (!rst && !stall),
        .grant (grant),
        .idx   (grant_idx)
    );

    // The arbiter only grants asserted requests, so any grant is a transfer.
    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        act_a = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                act_a = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (act_en) begin
            vld_d = {vld_q[LAT-2:0], transfer};
            id_d  = {id_q[LAT-2:0], grant_idx};
        end
        if (transfer) begin
            rr_ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    // NOTE: the ID stages are reset along with the valid bits even though only
    // valid qualifies them, so rsp_id reads 0 out of reset rather than X.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid = vld_q[LAT-1];
    assign rsp_id    = id_q[LAT-1];
    assign rsp_data  = act_y;
    assign busy      = |vld_q;

`ifdef SIGMOID_SCHED_PERF_EN
    logic [15:0] perf_grants_q, perf_grants_d;
    logic [15:0] perf_stalls_q, perf_stalls_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        perf_grants_d = perf_grants_q;
        perf_stalls_d = perf_stalls_q;
        if (transfer && (perf_grants_q != 16'hFFFF)) begin
            perf_grants_d = perf_grants_q + 16'd1;
        end
        if (!act_en && (perf_stalls_q != 16'hFFFF)) begin
            perf_stalls_d = perf_stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_grants_q <= perf_grants_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_sigmoid_sched.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_sched
// Bench for sigmoid_sched with a stand-in two-stage activation unit sharing
// clk/rst. A transaction-level model (queue of in-flight operations with their
// age in enabled cycles, plus its own round-robin pointer) predicts the DUT
// outputs every cycle; directed scenarios add hand-computed expectations.
// Define SIGMOID_SCHED_PERF_EN to exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_sigmoid_sched;
    import nn_pkg::*;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int LAT   = 2;
    localparam logic signed [WIDTH-1:0] SIX = 32'sh0600_0000;

    logic                  clk       = 1'b0;
    logic                  rst       = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data  = '0;
    logic                  rsp_ready = 1'b1;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  act_en;
    logic [WIDTH-1:0]      act_a;
    logic [WIDTH-1:0]      act_y;
    logic                  busy;
`ifdef SIGMOID_SCHED_PERF_EN
    logic [15:0]           perf_grants;
    logic [15:0]           perf_stalls;
`endif

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    sigmoid_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .act_en    (act_en),
        .act_a     (act_a),
        .act_y     (act_y),
        .busy      (busy)
`ifdef SIGMOID_SCHED_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`endif
    );

    // Stand-in activation transfer curve: saturates to +/-1.0 beyond +/-6.0,
    // otherwise a line through 32'h007F71A3 at zero.
    function automatic logic [WIDTH-1:0] sig_f(input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] sx;
        sx = x;
        if (sx >= SIX)  return ONE_POS;
        if (sx <= -SIX) return ONE_NEG;
        return 32'h007F_71A3 + WIDTH'(sx >>> 3);
    endfunction

    // Stand-in activation unit: two enabled stages, flushed by the shared reset.
    logic [WIDTH-1:0] s1_q, s2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (act_en) begin
            s1_q <= act_a;
            s2_q <= s1_q;
        end
    end
    assign act_y = sig_f(s2_q);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- requester driver: one source queue per requester -------
    logic [WIDTH-1:0] src [NREQ][$];

    always begin : driver
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) void'(src[i].pop_front());
            req_valid[i] = (src[i].size() != 0);
            req_data[i*WIDTH +: WIDTH] = (src[i].size() != 0) ? src[i][0] : '0;
        end
    end

    // ---------------- transaction model and per-cycle compare ----------------
    typedef struct {
        int               id;
        logic [WIDTH-1:0] a;
        int               age;
    } ent_t;

    ent_t             mq[$];
    int               m_ptr    = 0;
    int               m_grants = 0;
    int               m_stalls = 0;
    int               log_id[$];
    logic [WIDTH-1:0] log_data[$];
    int               log_cyc[$];

    always begin : compare
        bit               exp_valid;
        bit               exp_en;
        int               g;
        logic [NREQ-1:0]  exp_ready;
        logic [WIDTH-1:0] exp_a;
        int               obs_id;
        logic [WIDTH-1:0] obs_data;
        @(negedge clk);
        if (rst) begin
            check("rst_act_en", act_en, 1);
            check("rst_req_ready", req_ready, 0);
            @(posedge clk);
            mq.delete();
            m_ptr    = 0;
            m_grants = 0;
            m_stalls = 0;
        end else begin
            exp_valid = (mq.size() > 0) && (mq[0].age == LAT);
            exp_en    = !(exp_valid && !rsp_ready);
            g = -1;
            if (exp_en) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            exp_ready = '0;
            exp_a     = '0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                exp_a        = req_data[g*WIDTH +: WIDTH];
            end
            check("act_en", act_en, exp_en);
            check("req_ready", req_ready, exp_ready);
            check("act_a", act_a, exp_a);
            check("rsp_valid", rsp_valid, exp_valid);
            check("busy", busy, mq.size() > 0);
            if (exp_valid) begin
                check("rsp_id", rsp_id, mq[0].id);
                check("rsp_data", rsp_data, sig_f(mq[0].a));
            end
`ifdef SIGMOID_SCHED_PERF_EN
            check("perf_grants", perf_grants, (m_grants > 65535) ? 65535 : m_grants);
            check("perf_stalls", perf_stalls, (m_stalls > 65535) ? 65535 : m_stalls);
`endif
            obs_id   = int'(rsp_id);
            obs_data = rsp_data;
            @(posedge clk);
            if (exp_en) begin
                if (exp_valid) begin
                    log_id.push_back(obs_id);
                    log_data.push_back(obs_data);
                    log_cyc.push_back(cycle);
                    void'(mq.pop_front());
                end
                foreach (mq[j]) mq[j].age++;
                if (g >= 0) begin
                    mq.push_back('{g, exp_a, 1});
                    m_ptr = (g + 1) % NREQ;
                    m_grants++;
                end
            end else begin
                m_stalls++;
            end
        end
    end

    // ---------------- helpers for the directed scenarios ---------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int b;
        b = 0;
        while (log_id.size() < n && b < budget) begin
            @(posedge clk);
            #1;
            b++;
        end
        #1;
        check(name, log_id.size(), n);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int b;
        b = 0;
        @(negedge clk);
        while (!rsp_valid && b < budget) begin
            @(negedge clk);
            b++;
        end
        check(name, rsp_valid, 1);
    endtask

    // Entered at a negedge where a result is waiting and rsp_ready is low:
    // hold the stall for three cycles, then release.
    task automatic stall_window(input logic [WIDTH-1:0] exp_data);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            check("stall_act_en", act_en, 0);
            check("stall_req_ready", req_ready, '0);
            check("stall_rsp_data", rsp_data, exp_data);
        end
        tick();
        rsp_ready = 1'b1;
    endtask

    // ---------------- directed scenarios -------------------------------------
    initial begin : main
        int base;

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_busy", busy, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_act_en", act_en, 1);

        // All four requesters busy: strict rotation 0,1,2,3,0,1,2,3 back to back.
        tick();
        base = log_id.size();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++)
                src[i].push_back(32'h0010_0000 * (i + 1) + k);
        wait_log("rr_count", base + 8, 60);
        for (int j = 0; j < 8; j++) begin
            check("rr_id", log_id[base + j], j % 4);
            check("rr_data", log_data[base + j], sig_f(32'h0010_0000 * ((j % 4) + 1) + (j / 4)));
        end
        check("rr_throughput", log_cyc[base + 7] - log_cyc[base], 7);

        // Single request from requester 0 with operand 0.
        tick();
        base = log_id.size();
        src[0].push_back(32'h0000_0000);
        wait_log("single_count", base + 1, 20);
        check("single_id", log_id[base], 0);
        check("single_data", log_data[base], 32'h007F_71A3);
        #1;
        check("single_busy_low", busy, 0);

        // Saturation at +/-6.0; pointer now at 1, so 2 wins before 3.
        tick();
        base = log_id.size();
        src[2].push_back(32'h0600_0000);
        src[3].push_back(32'hFA00_0000);
        wait_log("sat_count", base + 2, 20);
        check("sat_id0", log_id[base], 2);
        check("sat_data0", log_data[base], 32'h0100_0000);
        check("sat_id1", log_id[base + 1], 3);
        check("sat_data1", log_data[base + 1], 32'hFF00_0000);

        // Four requests, consumer stalls three cycles on the first result.
        tick();
        base = log_id.size();
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) src[i].push_back(32'h0030_0000 + 32'h0001_0000 * i);
        wait_valid("stall_valid_seen", 20);
        stall_window(sig_f(32'h0030_0000));
        wait_log("stall_count", base + 4, 30);
        repeat (5) tick();
        check("stall_no_dup", log_id.size(), base + 4);
        for (int i = 0; i < NREQ; i++) begin
            check("stall_id", log_id[base + i], i);
            check("stall_data", log_data[base + i], sig_f(32'h0030_0000 + 32'h0001_0000 * i));
        end

        // Reset with two results in flight: both dropped, pointer back to 0.
        tick();
        base = log_id.size();
        rsp_ready = 1'b0;
        src[1].push_back(32'h0040_0000);
        src[2].push_back(32'h0050_0000);
        wait_valid("flush_valid_seen", 20);
        check("flush_two_in_flight", dut.vld_q, 2'b11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("flush_rsp_valid", rsp_valid, 0);
        check("flush_busy", busy, 0);
        repeat (4) tick();
        check("flush_no_stale", log_id.size(), base);
        src[3].push_back(32'h0060_0000);
        src[0].push_back(32'h0070_0000);
        wait_log("flush_count", base + 2, 20);
        check("flush_ptr_first", log_id[base], 0);
        check("flush_ptr_second", log_id[base + 1], 3);

`ifdef SIGMOID_SCHED_PERF_EN
        // Counters from a clean reset: 5 transfers and exactly 3 stall cycles.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = log_id.size();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) src[0].push_back(32'h0001_0000 * k);
        wait_valid("perf_valid_seen", 20);
        stall_window(sig_f(32'h0000_0000));
        wait_log("perf_count", base + 5, 30);
        repeat (2) tick();
        check("perf_grants_5", perf_grants, 16'd5);
        check("perf_stalls_3", perf_stalls, 16'd3);

        // Long stall pins the stall counter at its ceiling.
        base = log_id.size();
        rsp_ready = 1'b0;
        src[1].push_back(32'h0002_0000);
        src[1].push_back(32'h0003_0000);
        repeat (70010) @(posedge clk);
        #2;
        check("perf_stalls_sat", perf_stalls, 16'hFFFF);
        rsp_ready = 1'b1;
        wait_log("perf_sat_drain", base + 2, 20);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sigmoid_sched.md
Name: sigmoid_sched

Overview:
- Shares one pipelined sigmoid activation unit (Q8.24, 2-cycle latency) among NREQ neuron requesters.
- Round-robin arbitration with a valid/ready request handshake; results are tagged with the requester ID.
- Result backpressure freezes the activation pipeline through its enable.
- Sits between the neuron MAC outputs and the layer output buffer. It instantiates no sigmoid; it drives an external one via the act_* ports.

Parameters:
- WIDTH, 32, data width (Q8.24 fixed point).
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- LAT, 2, activation unit latency in enabled cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*WIDTH  packed pre-activations; requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant/accept.
- rsp_valid  out  1  result valid.
- rsp_id  out  IDW  requester that owns the result.
- rsp_data  out  WIDTH  activation result (driven from act_y).
- rsp_ready  in  1  consumer accepts the result.
- act_en  out  1  enable to the activation unit's pipeline registers.
- act_a  out  WIDTH  operand to the activation unit.
- act_y  in  WIDTH  activation unit output.
- busy  out  1  any result in flight.

Behaviour:
- Reset (sync, rst=1 at posedge) clears:
  - vld_pipe[LAT-1:0] to 0, id_pipe to 0, rr_ptr to 0.
  - Outputs: rsp_valid=0, rsp_id=0, busy=0, req_ready=0.
  - act_en=1 during reset, so the activation unit (sharing rst) flushes too.
  - A reset mid-operation drops all in-flight results; none are emitted afterwards.
- Stall:
  - act_en = !(vld_pipe[LAT-1] && !rsp_ready).
  - When act_en=0: vld_pipe, id_pipe and rr_ptr hold; req_ready=0.
- Arbitration (combinational, only when act_en=1):
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = onehot(g); act_a = req_data[g].
  - With no request: req_ready=0 and act_a=0.
  - req_ready never depends on req_ready; it may depend on req_valid.
- Handshake:
  - A request transfers when req_valid[i] && req_ready[i] at a posedge.
  - The requester holds valid and data stable until the transfer.
- Pointer: on a transfer, rr_ptr <= (g+1) mod NREQ; otherwise it holds.
- Pipeline tracking (on a posedge with act_en=1):
  - vld_pipe <= {vld_pipe[LAT-2:0], transfer}.
  - id_pipe shifts identically, carrying g.
- Response:
  - rsp_valid = vld_pipe[LAT-1]; rsp_id = id_pipe[LAT-1]; rsp_data = act_y.
  - A response completes when rsp_valid && rsp_ready.
  - Completion and a new grant may occur in the same cycle.
  - Full throughput is 1 result per cycle when rsp_ready is held high.
- Latency: transfer at edge N gives rsp_valid=1 in the cycle after edge N+LAT-1, i.e. LAT cycles after the request cycle when unstalled.
- busy = |vld_pipe.
- Ordering: responses come out strictly in grant order.
- No request is lost or duplicated under any rsp_ready pattern.

Optional Feature:
- Macro: SIGMOID_SCHED_PERF_EN.
- When defined, adds outputs:
  - perf_grants[15:0]: counts transfers.
  - perf_stalls[15:0]: counts cycles with act_en=0.
  - Both saturate at 16'hFFFF and are cleared by rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header/package (nn_pkg), include-guarded: Q8.24 constants (FL=24, ONE_POS=32'h01000000, ONE_NEG=32'hFF000000), default SIGMOID_LAT=2, clog2 function.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req, ptr, en. Output: one-hot grant plus encoded index.
  - Combinational.
  - Reused later by the layer-buffer write scheduler.

Test Plan (bench instantiates sigmoid sharing clk/rst):
- Single request 0 with data 32'h00000000, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=32'h007F71A3; busy falls next cycle.
- Requesters 0..3 all valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; one response per cycle with rsp_id sequence matching.
- Requester 2 with 32'h06000000, requester 3 with 32'hFA000000 (-6.0) -> responses (2, 32'h01000000) then (3, 32'hFF000000).
- Stream of 4 requests, rsp_ready low for 3 cycles while rsp_valid=1 -> act_en=0 and req_ready=0 during the stall; rsp_data stable; all 4 results delivered in order after release, none lost or duplicated.
- rst asserted for 1 cycle with 2 results in flight -> next cycle rsp_valid=0, busy=0, rr_ptr=0; no stale response afterwards.
- With SIGMOID_SCHED_PERF_EN: 5 transfers and 3 stall cycles -> perf_grants=5, perf_stalls=3; force 70000 stall cycles -> perf_stalls=16'hFFFF.
